// File: rtl/des_req_arbiter.sv
// des_req_arbiter: round-robin sharing of one DES core between two requesters,
// with operand latching, start sequencing and a per-operation timeout watchdog.
module des_req_arbiter #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Req0,
   input  logic        i_Dec0,
   input  logic [63:0] i_Key0,
   input  logic [63:0] i_Text0,
   input  logic        i_Req1,
   input  logic        i_Dec1,
   input  logic [63:0] i_Key1,
   input  logic [63:0] i_Text1,
   output logic        o_Gnt0,
   output logic        o_Gnt1,
   output logic        o_Done0,
   output logic        o_Done1,
   output logic        o_Err0,
   output logic        o_Err1,
   output logic [63:0] o_Data,
   output logic        o_Busy,
   output logic        o_Owner,
   output logic        o_DES_fStart,
   output logic        o_DES_fDec,
   output logic [63:0] o_DES_Key,
   output logic [63:0] o_DES_Text,
   input  logic        i_DES_fDone,
   input  logic [63:0] i_DES_Data
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;
   // Last WAIT count: the response then lands exactly TIMEOUT_CYC cycles after fStart
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYC - 2);
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rr;
   logic             w_go, w_sel, w_fin;
   always_comb begin
      w_go   = r_state == S_IDLE && (i_Req0 || i_Req1);
      w_sel  = (i_Req0 && i_Req1) ? r_rr : i_Req1;
      w_fin  = r_state == S_WAIT && (i_DES_fDone || r_cnt == LP_LAST);
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_go ? S_START : S_IDLE;
         S_START: w_next = S_WAIT;
         S_WAIT:  w_next = w_fin ? S_RESP : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_rr         <= 1'b0;
         o_Gnt0       <= 1'b0;
         o_Gnt1       <= 1'b0;
         o_Done0      <= 1'b0;
         o_Done1      <= 1'b0;
         o_Err0       <= 1'b0;
         o_Err1       <= 1'b0;
         o_Data       <= '0;
         o_Busy       <= 1'b0;
         o_Owner      <= 1'b0;
         o_DES_fStart <= 1'b0;
         o_DES_fDec   <= 1'b0;
         o_DES_Key    <= '0;
         o_DES_Text   <= '0;
      end else begin
         r_state      <= w_next;
         o_Busy       <= w_next != S_IDLE;
         o_Gnt0       <= w_go && !w_sel;
         o_Gnt1       <= w_go && w_sel;
         o_DES_fStart <= w_go;
         if (w_go) begin
            o_Owner    <= w_sel;
            o_DES_fDec <= w_sel ? i_Dec1 : i_Dec0;
            o_DES_Key  <= w_sel ? i_Key1 : i_Key0;
            o_DES_Text <= w_sel ? i_Text1 : i_Text0;
         end
         r_cnt <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
         // A done arriving in the timeout cycle still wins
         if (w_fin)
            o_Data <= i_DES_fDone ? i_DES_Data : '0;
         o_Done0 <= w_fin && !o_Owner;
         o_Done1 <= w_fin && o_Owner;
         o_Err0  <= w_fin && !i_DES_fDone && !o_Owner;
         o_Err1  <= w_fin && !i_DES_fDone && o_Owner;
         if (r_state == S_RESP)
            r_rr <= !o_Owner;
      end
   end
endmodule

// File: tb/tb_des_req_arbiter.sv
// tb_des_req_arbiter: scoreboard bench for des_req_arbiter with a behavioural DES core model.
module tb_des_req_arbiter;
   localparam int TO = 64;
   localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] T1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] R1 = 64'h85E8_1354_0F0A_B405;
   logic clk = 0;
   always #5 clk = ~clk;
   logic rst = 1, req0 = 0, dec0 = 0, req1 = 0, dec1 = 0;
   logic [63:0] key0 = 0, text0 = 0, key1 = 0, text1 = 0;
   logic gnt0, gnt1, done0, done1, err0, err1, busy, owner, fstart, fdec;
   logic [63:0] data, des_key, des_text;
   logic des_done = 0;
   logic [63:0] des_data = 0;
   des_req_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_Req0(req0), .i_Dec0(dec0), .i_Key0(key0), .i_Text0(text0),
      .i_Req1(req1), .i_Dec1(dec1), .i_Key1(key1), .i_Text1(text1),
      .o_Gnt0(gnt0), .o_Gnt1(gnt1), .o_Done0(done0), .o_Done1(done1),
      .o_Err0(err0), .o_Err1(err1), .o_Data(data), .o_Busy(busy), .o_Owner(owner),
      .o_DES_fStart(fstart), .o_DES_fDec(fdec), .o_DES_Key(des_key), .o_DES_Text(des_text),
      .i_DES_fDone(des_done), .i_DES_Data(des_data)
   );
   int n_chk = 0, n_fail = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] desf(input logic [63:0] k, input logic [63:0] t, input logic d);
      if (k == K1 && t == T1 && !d) return R1;
      return k ^ {t[31:0], t[63:32]} ^ {64{d}};
   endfunction
   // DES core model: done pulse des_delay cycles after fStart (0 = never)
   int des_delay = 0, dcnt = 0;
   logic spur = 0, fire = 0;
   logic [63:0] dret = 0;
   initial forever begin
      @(negedge clk);
      fire = 0;
      if (fstart) begin
         dcnt = des_delay;
         dret = desf(des_key, des_text, fdec);
      end else if (dcnt > 0) begin
         dcnt--;
         fire = dcnt == 0;
      end
      des_done = fire || spur;
      des_data = fire ? dret : 64'hDEAD_BEEF_0BAD_F00D;
   end
   typedef struct {logic port; logic [63:0] data; logic err; int cyc;} exp_t;
   exp_t sb[$];
   int svc[$];
   int cyc = 0;
   logic prev_gnt = 0, p = 0;
   exp_t e;
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         sb.delete();
         prev_gnt = 0;
      end else begin
         if (gnt0 || gnt1) begin
            p = gnt1;
            check("gnt_onehot", {63'd0, gnt0 && gnt1}, 0);
            check("gnt_width", {63'd0, prev_gnt}, 0);
            check("fstart", {63'd0, fstart}, 1);
            check("owner", {63'd0, owner}, {63'd0, p});
            check("des_key", des_key, p ? key1 : key0);
            check("des_text", des_text, p ? text1 : text0);
            check("des_dec", {63'd0, fdec}, {63'd0, p ? dec1 : dec0});
            e.port = p;
            e.err  = des_delay == 0 || des_delay >= TO;
            e.data = e.err ? 64'd0 : (p ? desf(key1, text1, dec1) : desf(key0, text0, dec0));
            e.cyc  = cyc + (e.err ? TO : des_delay + 1);
            sb.push_back(e);
            svc.push_back(int'(p));
         end
         prev_gnt = gnt0 || gnt1;
         if (done0 || done1 || err0 || err1) begin
            if (sb.size() == 0)
               check("unexp_done", {60'd0, done0, done1, err0, err1}, 0);
            else begin
               e = sb.pop_front();
               check("done_port", {62'd0, done1, done0}, e.port ? 2 : 1);
               check("err", {62'd0, err1, err0}, e.err ? (e.port ? 2 : 1) : 0);
               check("data", data, e.data);
               check("done_cyc", cyc, e.cyc);
            end
         end
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1;
      tick(2);
      rst = 0;
   endtask
   task automatic wait_gnt(output int lat);
      lat = 0;
      while (!(gnt0 || gnt1) && lat < 10) begin
         tick();
         lat++;
      end
      check("gnt_wait", {63'd0, lat < 10}, 1);
   endtask
   task automatic wait_idle(input int lim);
      int i = 0;
      while ((busy || sb.size() != 0) && i < lim) begin
         tick();
         i++;
      end
      check("idle_wait", {63'd0, i < lim}, 1);
   endtask
   task automatic op(input logic port, input logic dec, input logic [63:0] k,
                     input logic [63:0] t, input int dly, output int lat);
      des_delay = dly;
      if (port) begin
         dec1 = dec; key1 = k; text1 = t; req1 = 1;
      end else begin
         dec0 = dec; key0 = k; text0 = t; req0 = 1;
      end
      wait_gnt(lat);
      req0 = 0;
      req1 = 0;
      wait_idle(200);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      int lat;
      do_reset();
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_data", data, 0);
      check("rst_key", des_key, 0);
      check("rst_gnt", {62'd0, gnt1, gnt0}, 0);
      // basic encrypt, one-cycle grant latency
      op(0, 0, K1, T1, 3, lat);
      check("t1_lat", lat, 1);
      check("t1_data", data, R1);
      // timeout with no done at all
      op(0, 1, 64'hA5A5_0000_FFFF_1234, 64'h1111_2222_3333_4444, 0, lat);
      check("t3_busy", {63'd0, busy}, 0);
      check("t3_data", data, 0);
      // done in the very timeout cycle wins
      op(1, 0, 64'h0F0F_F0F0_1234_5678, 64'hCAFE_BABE_DEAD_BEEF, TO - 1, lat);
      check("t4_data", data, desf(64'h0F0F_F0F0_1234_5678, 64'hCAFE_BABE_DEAD_BEEF, 0));
      spur = 1;
      tick();
      spur = 0;
      tick(3);
      check("t4_spur_busy", {63'd0, busy}, 0);
      check("t4_spur_data", data, desf(64'h0F0F_F0F0_1234_5678, 64'hCAFE_BABE_DEAD_BEEF, 0));
      // both requesting from reset alternate 0,1,0,1
      do_reset();
      svc.delete();
      des_delay = 2;
      key0 = 64'h1; text0 = 64'h2; key1 = 64'h3; text1 = 64'h4; dec0 = 0; dec1 = 1;
      req0 = 1; req1 = 1;
      for (int i = 0; i < 100 && svc.size() < 4; i++) tick();
      req0 = 0; req1 = 0;
      wait_idle(200);
      check("t2_count", svc.size(), 4);
      for (int i = 0; i < 4 && i < svc.size(); i++) check($sformatf("t2_order%0d", i), svc[i], i % 2);
      // reset mid-WAIT, late done ignored
      do_reset();
      des_delay = 8;
      key0 = 64'h55; text0 = 64'h66; req0 = 1;
      wait_gnt(lat);
      req0 = 0;
      tick(3);
      rst = 1;
      tick();
      rst = 0;
      check("t5_busy", {63'd0, busy}, 0);
      check("t5_data", data, 0);
      check("t5_key", des_key, 0);
      check("t5_text", des_text, 0);
      check("t5_owner", {63'd0, owner}, 0);
      tick(6);
      check("t5_after_busy", {63'd0, busy}, 0);
      op(1, 0, 64'h7777_8888_9999_AAAA, 64'hBBBB_CCCC_DDDD_EEEE, 4, lat);
      // port 1 decrypt: dec and owner stay up through START..WAIT
      des_delay = 5;
      dec1 = 1; key1 = 64'hFEED_FACE_0000_0001; text1 = 64'h0000_0000_ABCD_0002; req1 = 1;
      wait_gnt(lat);
      req1 = 0;
      for (int i = 0; i < 20 && busy && !done1 && !done0; i++) begin
         check("t6_dec", {63'd0, fdec}, 1);
         check("t6_owner", {63'd0, owner}, 1);
         tick();
      end
      wait_idle(200);
      tick(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
